multi_tick_counter: RTL
=======================

Name: multi_tick_counter

Overview:
- Parametrised successor to the single-channel tick counter: NUM_CH independent WIDTH-bit tick counters, each with its own terminal count.
- Each channel has start/stop control and one-shot or periodic mode.
- Each channel emits a one-cycle watch pulse every time it reaches its terminal count.
- Used as the shared timer resource for watchdogs and periodic event generation.

Parameters:
- WIDTH, 8, bit width of each counter and of each terminal count.
- NUM_CH, 4, number of independent channels (1..16).

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  NUM_CH  per-channel start/restart pulse.
- stop_i  in  NUM_CH  per-channel abort pulse.
- mode_i  in  NUM_CH  per-channel mode, sampled with start_i: 0 = one-shot, 1 = periodic.
- n_ticks_i  in  NUM_CH*WIDTH  packed terminal counts; channel c occupies bits [c*WIDTH +: WIDTH]; sampled with start_i.
- data_o  out  NUM_CH*WIDTH  packed current counts.
- watch_o  out  NUM_CH  one-cycle terminal-count pulse per channel.
- busy_o  out  NUM_CH  channel running.

Behaviour:
- Reset: on an rst edge, every channel goes to ST_IDLE; data_o=0, watch_o=0, busy_o=0, latched limit=0, latched mode=0. rst overrides all other inputs; it aborts any run in progress and no watch pulse is generated.
- Each channel runs an independent FSM with states ST_IDLE and ST_RUN. All outputs are registered.
- Start:
  - start_i[c] with n_ticks!=0 at edge E0 latches limit and mode.
  - After E0: count=0, busy=1, state ST_RUN.
  - This applies in both ST_IDLE and ST_RUN (restart). A restart discards the old run and produces no watch pulse.
- Zero limit: start_i with n_ticks==0 is ignored; state and outputs are unchanged.
- Counting: in ST_RUN the count increments by 1 per edge.
- Terminal: at the edge where count==limit-1:
  - count<=0 and watch_o<=1 for exactly one cycle.
  - Periodic: stay in ST_RUN; the pulse period is exactly limit cycles.
  - One-shot: go to ST_IDLE, busy<=0 on the same edge; count holds 0.
- limit=1 in periodic mode: watch_o stays high on every cycle; count stays 0.
- limit=2^WIDTH-1 is the maximum period. Count never exceeds limit-1, so no arithmetic overflow is possible.
- Stop: stop_i[c] in ST_RUN gives ST_IDLE, busy=0, count=0, no watch pulse. stop_i in ST_IDLE has no effect.
- Simultaneous stop_i and start_i on the same channel: stop wins; the channel ends in ST_IDLE.
- Start coinciding with the terminal edge: the restart wins and watch_o is not asserted.
- Inputs to the block need no synchronisation; all are in the clk domain.

Optional Feature:
- Macro: MULTI_TICK_COUNTER_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 4, range 2..256).
  - A shared free-running prescaler, reset by rst, produces tick_en on one cycle in every PRESCALE.
  - Counters advance, and the terminal transition occurs, only on edges where tick_en=1.
  - start_i and stop_i still act on any edge.
  - The prescaler is never reset by start_i, so the first period may be short by up to PRESCALE-1 cycles.
- Not defined: tick_en is tied to 1 and the block behaves exactly as specified above.

Decomposition:
- Package multi_tick_counter_pkg:
  - typedef enum state_e {ST_IDLE, ST_RUN}.
  - typedef enum mode_e {MODE_ONESHOT=0, MODE_PERIODIC=1}.
  - Constants DEF_WIDTH=8, DEF_NUM_CH=4.
- Sub-module tick_channel: one channel's FSM, limit/mode latch and counter, with a tick_en input. Instantiated NUM_CH times in a generate loop.
- The prescaler stays in the top level.

Test Plan:
- Reset mid-run: ch0 periodic with limit 10, assert rst at count 5 -> next cycle data_o=0, busy_o=0; no watch_o in the following 20 cycles.
- One-shot: ch0 with limit 10, start at E0 -> watch_o[0] high only in the cycle after E10; busy_o[0] falls on the same edge; count holds 0.
- Periodic across channels: ch1 limit 3, ch2 limit 5, started together -> watch_o[1] at E3, E6, E9...; watch_o[2] at E5, E10...; coincident pulses at E15 both appear.
- Boundaries:
  - limit 1 periodic -> watch_o high every cycle.
  - limit 0 start -> busy_o stays 0.
  - limit 255 -> first watch at E255.
- Control conflicts:
  - Restart ch0 (limit 10) at count 7 with limit 4 -> next watch at E4 after the restart, none at the old terminal.
  - stop_i together with start_i -> idle.
  - stop_i at count 9 of limit 10 -> no pulse.
- With MULTI_TICK_COUNTER_PRESCALE_EN and PRESCALE=4: limit 5 periodic -> pulse spacing exactly 20 cycles after the first pulse.

Source files
------------

// File: rtl/multi_tick_counter_pkg.sv
// Shared types and defaults for the multi-channel tick counter.
package multi_tick_counter_pkg;

    // Per-channel FSM state; ST_RUN doubles as the busy flag.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Run mode latched together with the terminal count on start.
    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_CH = 4;

endpackage

// File: rtl/multi_tick_counter_channel.sv
// One channel of the multi-channel tick counter: limit/mode latch, up-counter
// and IDLE/RUN FSM. The counter only advances on cycles where tick_en_i is set;
// start and stop act on every cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | not counting; count held at 0, busy low
// ST_RUN  | counting towards limit-1; watch pulse and wrap at terminal
module tick_channel
    import multi_tick_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] n_ticks_i,
    output logic [WIDTH-1:0] count_o,
    output logic             watch_o,
    output logic             busy_o
);

    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_RUN  = ST_RUN;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    mode_e            mode_q,  mode_d;
    logic             watch_q, watch_d;
    logic             start_ok;
    logic             at_terminal;

    // Terminal compare; count never exceeds limit-1 so no overflow guard is needed.
    assign at_terminal = (count_q == (limit_q - WIDTH'(1)));

    // Next-state logic; priority is stop, then start, then counting.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        mode_d   = mode_q;
        watch_d  = 1'b0;
        start_ok = start_i && (n_ticks_i != '0);

        if (stop_i) begin
            // A stop also swallows a same-cycle start, so the channel stays idle.
            if (state_q == S_RUN) begin
                state_d = S_IDLE;
                count_d = '0;
            end
        end else if (start_ok) begin
            // Restart discards the old run, including a terminal on this edge.
            limit_d = n_ticks_i;
            mode_d  = mode_e'(mode_i);
            count_d = '0;
            state_d = S_RUN;
        end else if ((state_q == S_RUN) && tick_en_i) begin
            if (at_terminal) begin
                count_d = '0;
                watch_d = 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                    state_d = S_IDLE;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // State registers with synchronous reset; reset never emits a watch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= MODE_ONESHOT;
            watch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            watch_q <= watch_d;
        end
    end

    assign count_o = count_q;
    assign watch_o = watch_q;
    assign busy_o  = state_q[0];

endmodule

// File: rtl/multi_tick_counter.sv
// NUM_CH independent WIDTH-bit tick counters sharing one clock.
// Optional macro MULTI_TICK_COUNTER_PRESCALE_EN adds a shared free-running
// prescaler (parameter PRESCALE) that gates when the counters advance.
module multi_tick_counter
    import multi_tick_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_CH   = DEF_NUM_CH
`ifdef MULTI_TICK_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH-1:0]       stop_i,
    input  logic [NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH*WIDTH-1:0] n_ticks_i,
    output logic [NUM_CH*WIDTH-1:0] data_o,
    output logic [NUM_CH-1:0]       watch_o,
    output logic [NUM_CH-1:0]       busy_o
);

    logic tick_en;

`ifdef MULTI_TICK_COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;

    // tick_en fires on the last phase of each PRESCALE-cycle window. Start
    // does not realign the prescaler, so a run's first period may be short.
    assign tick_en = (presc_q == PW'(PRESCALE - 1));
    assign presc_d = tick_en ? '0 : presc_q + PW'(1);

    // Free-running prescaler, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick_en = 1'b1;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tick_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick_en_i (tick_en),
            .start_i   (start_i[c]),
            .stop_i    (stop_i[c]),
            .mode_i    (mode_i[c]),
            .n_ticks_i (n_ticks_i[c*WIDTH +: WIDTH]),
            .count_o   (data_o[c*WIDTH +: WIDTH]),
            .watch_o   (watch_o[c]),
            .busy_o    (busy_o[c])
        );
    end

endmodule
